ysyx_22040000_alu_arbiter: RTL and testbench

Shares one combinational `ysyx_22040000_ALU` instance between two requesters, e.g. the EXU and a multi-cycle helper such as the CSR/AGU path. Each requester has a valid/ready request channel and a valid/ready response channel. The arbiter grants one request per cycle and drives the ALU `sel/a/b` inputs. It registers `out` into a single response slot and returns the result to the granted requester one cycle later. At most one transaction is outstanding; back-to-back issue is allowed when the slot drains in the same cycle.

---
 rtl/ysyx_22040000_alu_arbiter.sv | 86 ++++++++
 tb/tb_ysyx_22040000_alu_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040000_alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters; ALU_ARB_RR_EN selects round-robin over fixed priority.
// Latency 1 cycle (accept in N, rsp_valid in N+1); req_ready drops while the owner stalls rsp_ready.
module ysyx_22040000_alu_arbiter #(
  parameter int DWIDTH      = 32,
  parameter int ALUOP_WIDTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [ALUOP_WIDTH-1:0] req_op0,
  input  logic [ALUOP_WIDTH-1:0] req_op1,
  input  logic [DWIDTH-1:0]      req_a0,
  input  logic [DWIDTH-1:0]      req_b0,
  input  logic [DWIDTH-1:0]      req_a1,
  input  logic [DWIDTH-1:0]      req_b1,
  output logic [1:0]             rsp_valid,
  input  logic [1:0]             rsp_ready,
  output logic [DWIDTH-1:0]      rsp_data,
  output logic [ALUOP_WIDTH-1:0] alu_sel,
  output logic [DWIDTH-1:0]      alu_a,
  output logic [DWIDTH-1:0]      alu_b,
  input  logic [DWIDTH-1:0]      alu_out
);

`ifdef ALU_ARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  typedef enum logic {IDLE, RESP} state_t;

  state_t state, state_nxt;
  logic   owner;
  logic   last_ptr;
  logic   can_issue;
  logic   fire;
  logic   gnt_idx;
  logic   contend_win;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    can_issue   = (state == IDLE) || rsp_ready[owner];
    fire        = can_issue && !reset && (req_valid != 2'b00);
    // On contention the requester that did not win last time goes first.
    contend_win = RR_EN ? ~last_ptr : 1'b0;
    gnt_idx     = 1'b0;
    if (fire) begin
      if (req_valid == 2'b10)      gnt_idx = 1'b1;
      else if (req_valid == 2'b11) gnt_idx = contend_win;
    end
    req_ready = 2'b00;
    if (fire) req_ready = gnt_idx ? 2'b10 : 2'b01;

    state_nxt = state;
    if (fire)                                    state_nxt = RESP;
    else if (state == RESP && rsp_ready[owner])  state_nxt = IDLE;
  end

  // Ungranted cycles present requester 0 so the ALU never sees X.
  always_comb begin
    alu_sel = gnt_idx ? req_op1 : req_op0;
    alu_a   = gnt_idx ? req_a1  : req_a0;
    alu_b   = gnt_idx ? req_b1  : req_b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_data <= '0;
      owner    <= 1'b0;
      last_ptr <= 1'b1;
    end else if (fire) begin
      rsp_data <= alu_out;
      owner    <= gnt_idx;
      last_ptr <= gnt_idx;
    end
  end

  assign rsp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_ysyx_22040000_alu_arbiter.sv
// Directed bench for ysyx_22040000_alu_arbiter with a behavioural ALU on the alu_* ports.
module tb_ysyx_22040000_alu_arbiter;

  localparam int DW = 32;
  localparam int OW = 4;
  localparam logic [OW-1:0] ALU_ADD  = 4'd0;
  localparam logic [OW-1:0] ALU_SUB  = 4'd1;
  localparam logic [OW-1:0] ALU_XOR  = 4'd2;
  localparam logic [OW-1:0] ALU_SLL  = 4'd3;
  localparam logic [OW-1:0] ALU_SRA  = 4'd4;
  localparam logic [OW-1:0] ALU_SLT  = 4'd5;
  localparam logic [OW-1:0] ALU_SLTU = 4'd6;

  logic          clock;
  logic          reset;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [OW-1:0] req_op0, req_op1;
  logic [DW-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [OW-1:0] alu_sel;
  logic [DW-1:0] alu_a, alu_b, alu_out;

  int checks = 0;
  int errors = 0;

  ysyx_22040000_alu_arbiter #(.DWIDTH(DW), .ALUOP_WIDTH(OW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    alu_out = '0;
    case (alu_sel)
      ALU_ADD:  alu_out = alu_a + alu_b;
      ALU_SUB:  alu_out = alu_a - alu_b;
      ALU_XOR:  alu_out = alu_a ^ alu_b;
      ALU_SLL:  alu_out = alu_a << alu_b[4:0];
      ALU_SRA:  alu_out = $signed(alu_a) >>> alu_b[4:0];
      ALU_SLT:  alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_out = {31'd0, alu_a < alu_b};
      default:  alu_out = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; req_valid = 2'b11; rsp_ready = 2'b00;
    req_op0 = ALU_ADD; req_op1 = ALU_ADD;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    step(); step();
    #1;
    check("rst_req_ready", {30'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Contention: SUB 10-3 vs XOR F0^FF
    req_valid = 2'b11; rsp_ready = 2'b11;
    req_op0 = ALU_SUB; req_a0 = 32'd10;  req_b0 = 32'd3;
    req_op1 = ALU_XOR; req_a1 = 32'hF0;  req_b1 = 32'hFF;
    for (int k = 0; k < 4; k++) begin
      logic [1:0]  exp_rdy;
      logic [31:0] exp_dat;
`ifdef ALU_ARB_RR_EN
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_dat = (k % 2 == 0) ? 32'd7 : 32'h0F;
`else
      exp_rdy = 2'b01;
      exp_dat = 32'd7;
`endif
      #1;
      check("cont_req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
      step();
      check("cont_rsp_valid", {30'd0, rsp_valid}, {30'd0, exp_rdy});
      check("cont_rsp_data", rsp_data, exp_dat);
    end
    req_valid = 2'b00;
    step();
    check("cont_drain", {30'd0, rsp_valid}, 32'd0);

    // Single ADD 5+7 on requester 0
    req_valid = 2'b01; rsp_ready = 2'b00;
    req_op0 = ALU_ADD; req_a0 = 32'd5; req_b0 = 32'd7;
    #1;
    check("single_req_ready", {30'd0, req_ready}, 32'd1);
    check("single_alu_a", alu_a, 32'd5);
    step();
    req_valid = 2'b00;
    check("single_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    check("single_rsp_data", rsp_data, 32'd12);
    rsp_ready = 2'b01;
    step();
    check("single_idle", {30'd0, rsp_valid}, 32'd0);
    check("single_hold", rsp_data, 32'd12);

    // Backpressure: owner 1 stalls; requester 0 waits
    req_valid = 2'b10; rsp_ready = 2'b00;
    req_op1 = ALU_XOR; req_a1 = 32'hF0; req_b1 = 32'hFF;
    step();
    req_valid = 2'b01; rsp_ready = 2'b01;
    req_op0 = ALU_ADD; req_a0 = 32'd5; req_b0 = 32'd7;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_req_ready", {30'd0, req_ready}, 32'd0);
      check("bp_alu_a_from_req0", alu_a, 32'd5);
      step();
      check("bp_rsp_valid", {30'd0, rsp_valid}, 32'd2);
      check("bp_rsp_data", rsp_data, 32'h0F);
    end
    rsp_ready = 2'b10;
    #1;
    check("bp_release_ready", {30'd0, req_ready}, 32'd1);
    step();
    check("bp_new_owner", {30'd0, rsp_valid}, 32'd1);
    check("bp_new_data", rsp_data, 32'd12);
    req_valid = 2'b00; rsp_ready = 2'b01;
    step();

    // Back-to-back SLL stream on requester 1
    rsp_ready = 2'b10;
    req_op1 = ALU_SLL; req_a1 = 32'd1;
    for (int k = 0; k < 5; k++) begin
      req_valid = 2'b10; req_b1 = k;
      #1;
      check("b2b_req_ready", {30'd0, req_ready}, 32'd2);
      step();
      check("b2b_rsp_valid", {30'd0, rsp_valid}, 32'd2);
      check("b2b_rsp_data", rsp_data, 32'd1 << k);
    end
    req_valid = 2'b00;
    step();
    check("b2b_idle", {30'd0, rsp_valid}, 32'd0);

    // Signed ops on requester 0
    req_valid = 2'b01; rsp_ready = 2'b01;
    req_op0 = ALU_SRA; req_a0 = 32'h8000_0000; req_b0 = 32'd4;
    step();
    check("sra", rsp_data, 32'hF800_0000);
    req_op0 = ALU_SLT; req_a0 = 32'hFFFF_FFFF; req_b0 = 32'd1;
    step();
    check("slt", rsp_data, 32'd1);
    req_op0 = ALU_SLTU;
    step();
    check("sltu", rsp_data, 32'd0);
    req_valid = 2'b00;
    step();

    // Reset while a response is pending
    req_valid = 2'b01; rsp_ready = 2'b00;
    req_op0 = ALU_ADD; req_a0 = 32'd5; req_b0 = 32'd7;
    step();
    check("mid_pending", {30'd0, rsp_valid}, 32'd1);
    req_valid = 2'b00; reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("mid_rsp_data", rsp_data, 32'd0);
    req_valid = 2'b11; rsp_ready = 2'b11;
    req_op0 = ALU_SUB; req_a0 = 32'd10; req_b0 = 32'd3;
    req_op1 = ALU_XOR; req_a1 = 32'hF0; req_b1 = 32'hFF;
    #1;
    check("mid_first_grant", {30'd0, req_ready}, 32'd1);
    step();
    check("mid_first_data", rsp_data, 32'd7);
    req_valid = 2'b00;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
